// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: mnemonic codes, MIPS opcode/funct constants, encoding helpers
// and the loader state type. The LI2 state exists only when PSEUDO_LI_EN is
// defined; otherwise LI is just another illegal mnemonic.
package mips_isa_pkg;

   // Mnemonic codes carried on req_op; 19..31 are undefined.
   typedef enum logic [4:0] {
      OP_ADDU  = 5'd0,
      OP_SUBU  = 5'd1,
      OP_AND   = 5'd2,
      OP_OR    = 5'd3,
      OP_SLTU  = 5'd4,
      OP_MULTU = 5'd5,
      OP_MFLO  = 5'd6,
      OP_MFHI  = 5'd7,
      OP_JR    = 5'd8,
      OP_LW    = 5'd9,
      OP_SW    = 5'd10,
      OP_BEQ   = 5'd11,
      OP_BNE   = 5'd12,
      OP_ADDIU = 5'd13,
      OP_ORI   = 5'd14,
      OP_LUI   = 5'd15,
      OP_J     = 5'd16,
      OP_JAL   = 5'd17,
      OP_LI    = 5'd18
   } mnemonic_e;

   // Primary opcodes.
   localparam logic [5:0] OPC_SPECIAL = 6'b000000;
   localparam logic [5:0] OPC_J       = 6'b000010;
   localparam logic [5:0] OPC_JAL     = 6'b000011;
   localparam logic [5:0] OPC_BEQ     = 6'b000100;
   localparam logic [5:0] OPC_BNE     = 6'b000101;
   localparam logic [5:0] OPC_ADDIU   = 6'b001001;
   localparam logic [5:0] OPC_ORI     = 6'b001101;
   localparam logic [5:0] OPC_LUI     = 6'b001111;
   localparam logic [5:0] OPC_LW      = 6'b100011;
   localparam logic [5:0] OPC_SW      = 6'b101011;

   // SPECIAL funct codes.
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // R-type word: {SPECIAL, rs, rt, rd, shamt=0, funct}.
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {OPC_SPECIAL, rs, rt, rd, 5'd0, fn};
   endfunction

   // I-type word: {op, rs, rt, imm16}.
   function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm16);
      return {opc, rs, rt, imm16};
   endfunction

`ifdef PSEUDO_LI_EN
   // ISSUE accepts requests; LI2 emits the second (ORI) half of a split LI.
   typedef enum logic {
      ST_ISSUE = 1'b0,
      ST_LI2   = 1'b1
   } state_e;
`else
   typedef enum logic {
      ST_ISSUE = 1'b0
   } state_e;
`endif

endpackage

// File: rtl/instr_encoder.sv
// instr_encoder: purely combinational mapping of a mnemonic and its fields to
// one 32-bit MIPS word. LI is not a single machine instruction, so it (and
// every undefined code) reports legal=0 and is handled by the loader.
module instr_encoder
   import mips_isa_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [25:0] imm26,
   output logic [31:0] word,
   output logic        legal
);

   logic [15:0] imm16;
   assign imm16 = imm26[15:0];

   // Select the encoding for the requested mnemonic; defaults cover illegal codes.
   always_comb begin
      word  = 32'd0;
      legal = 1'b1;
      case (op)
         OP_ADDU:  word = enc_r(rs, rt, rd, FN_ADDU);
         OP_SUBU:  word = enc_r(rs, rt, rd, FN_SUBU);
         OP_AND:   word = enc_r(rs, rt, rd, FN_AND);
         OP_OR:    word = enc_r(rs, rt, rd, FN_OR);
         OP_SLTU:  word = enc_r(rs, rt, rd, FN_SLTU);
         OP_MULTU: word = enc_r(rs, rt, REG_ZERO, FN_MULTU);
         OP_MFLO:  word = enc_r(REG_ZERO, REG_ZERO, rd, FN_MFLO);
         OP_MFHI:  word = enc_r(REG_ZERO, REG_ZERO, rd, FN_MFHI);
         OP_JR:    word = enc_r(rs, REG_ZERO, REG_ZERO, FN_JR);
         OP_LW:    word = enc_i(OPC_LW, rs, rt, imm16);
         OP_SW:    word = enc_i(OPC_SW, rs, rt, imm16);
         OP_BEQ:   word = enc_i(OPC_BEQ, rs, rt, imm16);
         OP_BNE:   word = enc_i(OPC_BNE, rs, rt, imm16);
         OP_ADDIU: word = enc_i(OPC_ADDIU, rs, rt, imm16);
         OP_ORI:   word = enc_i(OPC_ORI, rs, rt, imm16);
         OP_LUI:   word = enc_i(OPC_LUI, REG_ZERO, rt, imm16);
         OP_J:     word = {OPC_J, imm26};
         OP_JAL:   word = {OPC_JAL, imm26};
         default:  legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/program_loader.sv
// program_loader: accepts encode requests and writes the encoded words
// sequentially into instruction memory, one cycle after acceptance.
// Optional feature macro: PSEUDO_LI_EN (expands LI into LUI/ORI; when
// undefined LI is rejected as an illegal op and there is no LI2 state).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high and clear is low; req_ready depends only on the
// current state and fill level, never on req_valid.
module program_loader
   import mips_isa_pkg::*;
#(
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [4:0]            req_op,
   input  logic [4:0]            req_rs,
   input  logic [4:0]            req_rt,
   input  logic [4:0]            req_rd,
   input  logic [31:0]           req_imm,
   output logic                  imem_we,
   output logic [31:0]           imem_addr,
   output logic [31:0]           imem_wdata,
   output logic [DEPTH_LOG2:0]   word_count,
   output logic                  full,
   output logic                  err_illegal,
   output logic                  err_overflow,
   output logic                  fsm_state
);

   localparam int CW = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH     = CW'(2 ** DEPTH_LOG2);
   localparam logic [CW-1:0] LAST_SLOT = CW'(2 ** DEPTH_LOG2 - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] ptr_q;
   logic [31:0]   enc_word;
   logic          enc_legal;
   logic          wr_en;
   logic [31:0]   wr_word;
   logic          set_illegal;
   logic          set_overflow;
   logic          one_free;

   instr_encoder u_enc (
      .op    (req_op),
      .rs    (req_rs),
      .rt    (req_rt),
      .rd    (req_rd),
      .imm26 (req_imm[25:0]),
      .word  (enc_word),
      .legal (enc_legal)
   );

   assign full       = (ptr_q == DEPTH);
   assign one_free   = (ptr_q == LAST_SLOT);
   assign word_count = ptr_q;
   assign fsm_state  = state_q;

`ifdef PSEUDO_LI_EN
   logic        li_load;
   logic [31:0] pending_q;
   logic        is_li;
   logic        li_split;

   assign is_li    = (req_op == OP_LI);
   assign li_split = (req_imm[31:16] != 16'd0);
`else
   logic unused_imm;
   assign unused_imm = ^req_imm[31:26];
`endif

   // Next-state and write-control decode; clear overrides everything.
   always_comb begin
      state_d      = state_q;
      req_ready    = 1'b0;
      wr_en        = 1'b0;
      wr_word      = enc_word;
      set_illegal  = 1'b0;
      set_overflow = 1'b0;
`ifdef PSEUDO_LI_EN
      li_load      = 1'b0;
`endif
      case (state_q)
         ST_ISSUE: begin
            req_ready = !full;
            if (req_valid && !full && !clear) begin
`ifdef PSEUDO_LI_EN
               if (is_li) begin
                  wr_en = 1'b1;
                  if (li_split) begin
                     wr_word = enc_i(OPC_LUI, REG_ZERO, req_rt, req_imm[31:16]);
                     if (one_free) begin
                        set_overflow = 1'b1;
                     end else begin
                        li_load = 1'b1;
                        state_d = ST_LI2;
                     end
                  end else begin
                     wr_word = enc_i(OPC_ORI, REG_ZERO, req_rt, req_imm[15:0]);
                  end
               end else
`endif
               if (enc_legal) begin
                  wr_en = 1'b1;
               end else begin
                  set_illegal = 1'b1;
               end
            end
         end
`ifdef PSEUDO_LI_EN
         ST_LI2: begin
            wr_en   = 1'b1;
            wr_word = pending_q;
            state_d = ST_ISSUE;
         end
`endif
         default: state_d = ST_ISSUE;
      endcase
      if (clear) begin
         state_d = ST_ISSUE;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_ISSUE;
      end else begin
         state_q <= state_d;
      end
   end

   // Write port, pointer and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q        <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= 32'd0;
         imem_wdata   <= 32'd0;
         err_illegal  <= 1'b0;
         err_overflow <= 1'b0;
      end else if (clear) begin
         ptr_q        <= '0;
         imem_we      <= 1'b0;
         err_illegal  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         imem_we <= wr_en;
         if (wr_en) begin
            imem_wdata <= wr_word;
            imem_addr  <= 32'({ptr_q, 2'b00});
            ptr_q      <= ptr_q + CW'(1);
         end
         if (set_illegal) begin
            err_illegal <= 1'b1;
         end
         if (set_overflow) begin
            err_overflow <= 1'b1;
         end
      end
   end

`ifdef PSEUDO_LI_EN
   // Second half of a split LI: ORI rt,rt,imm[15:0], captured at acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= 32'd0;
      end else if (li_load) begin
         pending_q <= enc_i(OPC_ORI, req_rt, req_rt, req_imm[15:0]);
      end
   end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scenario tasks with inline checks plus a write-port
// scoreboard ({addr, data} expected queue popped on every imem_we).
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = 5'd0;
   logic [4:0]  req_rs = 5'd0;
   logic [4:0]  req_rt = 5'd0;
   logic [4:0]  req_rd = 5'd0;
   logic [31:0] req_imm = 32'd0;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [6:0]  word_count;
   logic        full;
   logic        err_illegal;
   logic        err_overflow;
   logic        fsm_state;

   int tests_run = 0;
   int tests_failed = 0;
   int exp_ptr = 0;
   int cycle = 0;
   logic [63:0] exp_q[$];

   program_loader #(.DEPTH_LOG2(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_rs       (req_rs),
      .req_rt       (req_rt),
      .req_rd       (req_rd),
      .req_imm      (req_imm),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .word_count   (word_count),
      .full         (full),
      .err_illegal  (err_illegal),
      .err_overflow (err_overflow),
      .fsm_state    (fsm_state)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   // Reference encoding written straight from the MIPS field layout.
   function automatic logic [31:0] model_word(input logic [4:0] op, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [4:0] rd,
                                              input logic [31:0] imm);
      case (op)
         5'd0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
         5'd1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
         5'd2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
         5'd3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
         5'd4:  return {6'h00, rs, rt, rd, 5'd0, 6'h2b};
         5'd5:  return {6'h00, rs, rt, 10'd0, 6'h19};
         5'd6:  return {16'd0, rd, 5'd0, 6'h12};
         5'd7:  return {16'd0, rd, 5'd0, 6'h10};
         5'd8:  return {6'h00, rs, 15'd0, 6'h08};
         5'd9:  return {6'h23, rs, rt, imm[15:0]};
         5'd10: return {6'h2b, rs, rt, imm[15:0]};
         5'd11: return {6'h04, rs, rt, imm[15:0]};
         5'd12: return {6'h05, rs, rt, imm[15:0]};
         5'd13: return {6'h09, rs, rt, imm[15:0]};
         5'd14: return {6'h0d, rs, rt, imm[15:0]};
         5'd15: return {6'h0f, 5'd0, rt, imm[15:0]};
         5'd16: return {6'h02, imm[25:0]};
         5'd17: return {6'h03, imm[25:0]};
         default: return 32'd0;
      endcase
   endfunction

   // Scoreboard: every write must match the oldest expected {addr, data}.
   always @(negedge clk) begin
      if (reset && imem_we) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected_write addr=%h data=%h (no write expected)", imem_addr, imem_wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({imem_addr, imem_wdata} !== e) begin
               tests_failed++;
               $display("FAIL sb_write got addr=%h data=%h expected addr=%h data=%h",
                        imem_addr, imem_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic push_exp(input logic [31:0] data);
      exp_q.push_back({32'(exp_ptr * 4), data});
      exp_ptr++;
   endtask

   // Present a request at the falling edge and hold it until accepted (bounded).
   // Legal non-LI ops push their expected word when accepted.
   task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm);
      int waited;
      waited = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout op=%0d ready=%b expected ready=1", op, req_ready);
         req_valid = 1'b0;
      end else begin
         if (op <= 5'd17) push_exp(model_word(op, rs, rt, rd, imm));
         @(posedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
      clear = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      req_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      exp_ptr = 0;
   endtask

   task automatic test_reset();
      #1;
      tests_run++;
      if ({imem_we, imem_wdata, word_count, full, err_illegal, err_overflow, fsm_state} !== 44'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs got we=%b wdata=%h cnt=%0d full=%b ill=%b ovf=%b st=%b expected all 0",
                  imem_we, imem_wdata, word_count, full, err_illegal, err_overflow, fsm_state);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready got %b expected 1", req_ready);
      end
   endtask

   task automatic test_addu();
      send(5'd0, 5'd1, 5'd2, 5'd3, 32'd0);
      #1;
      tests_run++;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h0, 32'h00221821}) begin
         tests_failed++;
         $display("FAIL addu_latency got we=%b addr=%h data=%h expected we=1 addr=0 data=00221821",
                  imem_we, imem_addr, imem_wdata);
      end
      idle();
   endtask

   task automatic test_encodings();
      do_clear();
      for (int op = 0; op <= 17; op++) begin
         send(5'(op), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), $urandom());
      end
      idle();
      #1;
      tests_run++;
      if (word_count !== 7'd18) begin
         tests_failed++;
         $display("FAIL enc_count got %0d expected 18", word_count);
      end
   endtask

   task automatic test_back_to_back();
      int first_c;
      do_clear();
      send(5'd13, 5'd1, 5'd2, 5'd0, 32'h1111);
      first_c = cycle;
      for (int i = 0; i < 7; i++) begin
         send(5'($urandom_range(0, 4)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 32'd0);
      end
      tests_run++;
      if (cycle - first_c !== 7) begin
         tests_failed++;
         $display("FAIL b2b_cycles got %0d expected 7", cycle - first_c);
      end
      idle();
   endtask

   task automatic test_illegal();
      do_clear();
      send(5'd0, 5'd4, 5'd5, 5'd6, 32'd0);
      send(5'd31, 5'd1, 5'd1, 5'd1, 32'd0);
      #1;
      tests_run++;
      if ({imem_we, err_illegal, word_count} !== {1'b0, 1'b1, 7'd1}) begin
         tests_failed++;
         $display("FAIL illegal_31 got we=%b ill=%b cnt=%0d expected we=0 ill=1 cnt=1",
                  imem_we, err_illegal, word_count);
      end
      send(5'd19, 5'd1, 5'd1, 5'd1, 32'd0);
      idle();
      do_clear();
      #1;
      tests_run++;
      if ({err_illegal, word_count} !== {1'b0, 7'd0}) begin
         tests_failed++;
         $display("FAIL illegal_clear got ill=%b cnt=%0d expected ill=0 cnt=0", err_illegal, word_count);
      end
   endtask

   task automatic test_clear_priority();
      do_clear();
      send(5'd3, 5'd7, 5'd8, 5'd9, 32'd0);
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 5'd0;
      clear = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if ({imem_we, word_count, fsm_state} !== {1'b0, 7'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL clear_priority got we=%b cnt=%0d st=%b expected we=0 cnt=0 st=0",
                  imem_we, word_count, fsm_state);
      end
      idle();
      exp_ptr = 0;
   endtask

`ifdef PSEUDO_LI_EN
   task automatic test_li();
      do_clear();
      push_exp(32'h3C081234);
      push_exp(32'h35085678);
      send(5'd18, 5'd0, 5'd8, 5'd0, 32'h12345678);
      #1;
      tests_run++;
      if ({req_ready, fsm_state} !== 2'b01) begin
         tests_failed++;
         $display("FAIL li_split_state got ready=%b st=%b expected ready=0 st=1", req_ready, fsm_state);
      end
      // ADDU queued behind the split LI must wait out the LI2 cycle.
      send(5'd0, 5'd1, 5'd2, 5'd3, 32'd0);
      push_exp(32'h34080042);
      send(5'd18, 5'd0, 5'd8, 5'd0, 32'h00000042);
      #1;
      tests_run++;
      if ({req_ready, fsm_state, word_count} !== {1'b1, 1'b0, 7'd4}) begin
         tests_failed++;
         $display("FAIL li_single got ready=%b st=%b cnt=%0d expected ready=1 st=0 cnt=4",
                  req_ready, fsm_state, word_count);
      end
      // Clear while in LI2 drops the ORI half.
      push_exp(32'h3C090001);
      send(5'd18, 5'd0, 5'd9, 5'd0, 32'h00010002);
      @(negedge clk);
      req_valid = 1'b0;
      clear = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if ({imem_we, fsm_state, word_count} !== {1'b0, 1'b0, 7'd0}) begin
         tests_failed++;
         $display("FAIL li2_clear got we=%b st=%b cnt=%0d expected we=0 st=0 cnt=0",
                  imem_we, fsm_state, word_count);
      end
      idle();
      exp_ptr = 0;
   endtask

   task automatic test_reset_in_li2();
      do_clear();
      push_exp(32'h3C081234);
      send(5'd18, 5'd0, 5'd8, 5'd0, 32'h12345678);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      tests_run++;
      if ({imem_we, imem_wdata, fsm_state, word_count} !== {1'b0, 32'd0, 1'b0, 7'd0}) begin
         tests_failed++;
         $display("FAIL reset_li2 got we=%b wdata=%h st=%b cnt=%0d expected we=0 wdata=0 st=0 cnt=0",
                  imem_we, imem_wdata, fsm_state, word_count);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_ptr = 0;
      send(5'd17, 5'd0, 5'd0, 5'd0, 32'h00000100);
      #1;
      tests_run++;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h0, 32'h0C000100}) begin
         tests_failed++;
         $display("FAIL jal_after_reset got we=%b addr=%h data=%h expected we=1 addr=0 data=0C000100",
                  imem_we, imem_addr, imem_wdata);
      end
      idle();
   endtask
`else
   task automatic test_li_disabled();
      do_clear();
      send(5'd18, 5'd0, 5'd8, 5'd0, 32'h12345678);
      #1;
      tests_run++;
      if ({imem_we, err_illegal, word_count, fsm_state} !== {1'b0, 1'b1, 7'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL li_disabled got we=%b ill=%b cnt=%0d st=%b expected we=0 ill=1 cnt=0 st=0",
                  imem_we, err_illegal, word_count, fsm_state);
      end
      idle();
   endtask
`endif

   task automatic test_overflow();
      do_clear();
      for (int i = 0; i < 63; i++) begin
         send(5'd13, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd0, $urandom());
      end
`ifdef PSEUDO_LI_EN
      push_exp(32'h3C080001);
      send(5'd18, 5'd0, 5'd8, 5'd0, 32'h00010001);
`else
      send(5'd9, 5'd2, 5'd3, 5'd0, 32'h0000ABCD);
`endif
      #1;
      tests_run++;
`ifdef PSEUDO_LI_EN
      if ({imem_addr, err_overflow, full, word_count, req_ready, fsm_state} !== {32'hFC, 1'b1, 1'b1, 7'd64, 1'b0, 1'b0}) begin
`else
      if ({imem_addr, err_overflow, full, word_count, req_ready, fsm_state} !== {32'hFC, 1'b0, 1'b1, 7'd64, 1'b0, 1'b0}) begin
`endif
         tests_failed++;
         $display("FAIL overflow_state got addr=%h ovf=%b full=%b cnt=%0d ready=%b st=%b",
                  imem_addr, err_overflow, full, word_count, req_ready, fsm_state);
      end
      // A request offered while full must be ignored; the scoreboard flags any write.
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 5'd0;
      repeat (3) @(negedge clk);
      req_valid = 1'b0;
      #1;
      tests_run++;
      if ({imem_we, word_count, full} !== {1'b0, 7'd64, 1'b1}) begin
         tests_failed++;
         $display("FAIL full_hold got we=%b cnt=%0d full=%b expected we=0 cnt=64 full=1",
                  imem_we, word_count, full);
      end
      do_clear();
      #1;
      tests_run++;
      if ({full, err_overflow, req_ready} !== 3'b001) begin
         tests_failed++;
         $display("FAIL full_clear got full=%b ovf=%b ready=%b expected 0 0 1", full, err_overflow, req_ready);
      end
   endtask

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog expired before the end of the sequence");
      $fatal(1, "watchdog");
   end

   // Scenario sequence and final report.
   initial begin
      test_reset();
      test_addu();
      test_encodings();
      test_back_to_back();
      test_illegal();
      test_clear_priority();
`ifdef PSEUDO_LI_EN
      test_li();
      test_reset_in_li2();
`else
      test_li_disabled();
`endif
      test_overflow();
      repeat (3) @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_drain got %0d pending writes expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
